pp_rd_burst_sched: RTL and testbench
====================================

Name: pp_rd_burst_sched

Overview:
- Read-side scheduler for the ping-pong async FIFO pair, clocked on rd_clk.
- Watches the empty flag and readable count from the two read-side FIFO controllers (FIFO0, FIFO1).
- Drains them alternately in fixed-length bursts, or a short burst after a timeout, into one valid/ready output stream.
- Sits directly downstream of the read controllers: drives their rd_en and consumes their RAM read data.

Parameters:
DATA_SIZE, 16, data width
DEPTH_SIZE, 10, FIFO depth = 2^DEPTH_SIZE; count width DEPTH_SIZE+1
BURST_LEN, 64, beats per full burst (1..2^DEPTH_SIZE)
FLUSH_TMO, 256, rd_clk cycles a non-empty FIFO may sit below BURST_LEN before a partial burst is forced (0 = never)

Ports:
rd_clk  in  1  read-domain clock
rst_n  in  1  reset, asynchronous, active-low
f0_empty  in  1  FIFO0 empty flag
f0_count  in  DEPTH_SIZE+1  FIFO0 readable words (registered, conservative)
f0_dout  in  DATA_SIZE  FIFO0 RAM data, valid 1 cycle after f0_rd_en
f0_rd_en  out  1  FIFO0 read strobe
f1_empty, f1_count, f1_dout, f1_rd_en  same for FIFO1
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts
out_data  out  DATA_SIZE  output word
out_sel  out  1  source FIFO of out_data
out_last  out  1  final beat of a burst

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; last_sel = 1, so FIFO0 has first priority.
  - Timers, beat counter and output buffer cleared.
- Reset mid-burst: everything returns to these values immediately; in-flight read data is discarded.
- FSM states:
  - IDLE: select a source; no reads issued.
  - BURST: issue reads from the selected FIFO until the burst length is reached.
- Eligibility (per FIFO n), evaluated in IDLE:
  - full_ok: fn_count >= BURST_LEN.
  - tmo_ok: tmo_n == FLUSH_TMO, FLUSH_TMO != 0, and fn_empty = 0.
- Per-FIFO timeout counter tmo_n:
  - Increments while 0 < fn_count < BURST_LEN and FIFO n is not the active burst source; saturates at FLUSH_TMO.
  - Clears when fn_count == 0, fn_count >= BURST_LEN, or a burst from FIFO n starts.
- Source selection in IDLE:
  - Candidate order is !last_sel first, then last_sel.
  - First pass picks the first candidate with full_ok; if none, the first with tmo_ok.
  - Selected FIFO gives burst length L: BURST_LEN if full_ok, else fn_count sampled that cycle.
  - Latch sel and L, set last_sel = sel, go to BURST next cycle.
  - If no candidate qualifies, stay in IDLE.
- BURST:
  - fsel_rd_en = 1 in a cycle iff (occ + infl) < 3 and fsel_empty = 0.
  - occ is output-buffer occupancy; infl is 1 if a read was issued last cycle.
  - Each issue increments beat counter b. The issue with b == L-1 is the last; return to IDLE next cycle (1-cycle gap between bursts).
  - The other FIFO's rd_en is always 0. Both rd_en are never high together.
- Data path:
  - Read issued in cycle t: fsel_dout sampled at the end of cycle t+1 and written to a 3-entry output buffer with its sel and last tag.
  - out_valid rises in cycle t+2 at earliest (rd_en-to-out_valid latency 2).
  - The buffer never overflows, because credit counts in-flight reads.
  - No combinational path from out_ready to any rd_en.
- Output handshake:
  - A word pops when out_valid & out_ready.
  - out_data, out_sel and out_last stay stable while out_valid & !out_ready.
  - With out_ready held 1, sustained throughput is 1 word/cycle inside a burst.
- Boundary cases:
  - An empty flag rising mid-burst (should not occur, since count is conservative) stalls issue without aborting; the burst resumes when empty falls.
  - Simultaneous push and pop of the buffer is legal; occupancy is unchanged.
  - Count values are read only in IDLE, so a count changing during BURST has no effect.
  - Counters use DEPTH_SIZE+1 bits; comparisons are unsigned.

Test Plan:
1. Reset with f0_count = 64, f1_count = 64, out_ready = 1, BURST_LEN = 64.
   - Required: 64 words with out_sel = 0, then 1 idle gap, then 64 words with out_sel = 1.
   - out_last is high on word 64 of each burst; back-to-back out_valid within each burst.
2. f0_count = 200, f1_count = 0.
   - Required: bursts from FIFO0 only, each 64 beats; no f1_rd_en ever.
   - Alternation resumes once f1_count >= 64.
3. f1_count = 5 held, f0_count = 0, FLUSH_TMO = 256.
   - Required: no read for 256 cycles, then a 5-beat burst with out_sel = 1.
   - out_last is on beat 5; tmo_1 is cleared afterwards.
4. out_ready toggled 1-in-3 during a 64-beat burst.
   - Required: no word lost or duplicated, and the data order matches the FIFO contents.
   - occ + infl never exceeds 3; held outputs are stable while stalled.
5. Assert rst_n low at beat 20 of a burst, release it, then present the same counts.
   - Required: all outputs go to 0 immediately.
   - The first burst after reset comes from FIFO0, with the full 64 beats.
6. Both FIFOs full_ok after a FIFO1 burst.
   - Required: FIFO0 is selected next, giving strict alternation (0, 1, 0, 1) over 8 bursts.

Source files
------------

// File: rtl/pp_rd_burst_sched.sv
// Read-side burst scheduler for the ping-pong FIFO pair: drains FIFO0/FIFO1 alternately in
// full bursts (or a timed-out partial burst) into one valid/ready stream.
module pp_rd_burst_sched #(
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned DEPTH_SIZE = 10,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned FLUSH_TMO  = 256
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 f0_empty,
    input  logic [DEPTH_SIZE:0]  f0_count,
    input  logic [DATA_SIZE-1:0] f0_dout,
    output logic                 f0_rd_en,
    input  logic                 f1_empty,
    input  logic [DEPTH_SIZE:0]  f1_count,
    input  logic [DATA_SIZE-1:0] f1_dout,
    output logic                 f1_rd_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_sel,
    output logic                 out_last
);
    localparam int unsigned   CW       = DEPTH_SIZE + 1;
    localparam int unsigned   TW       = (FLUSH_TMO > 1) ? $clog2(FLUSH_TMO + 1) : 1;
    localparam logic [CW-1:0] BurstLen = CW'(BURST_LEN);
    localparam logic [TW-1:0] FlushTmo = TW'(FLUSH_TMO);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;
    state_e state_q, state_d;

    logic [1:0]           empty, full_ok, tmo_ok;
    logic [1:0][CW-1:0]   count;
    logic [1:0][TW-1:0]   tmo_q, tmo_d;
    logic                 last_sel_q, sel_q, cand0;
    logic [CW-1:0]        len_q, beat_q, pick_len;
    logic                 pick_valid, pick, pick_full, start;
    logic                 credit_ok, issue, last_issue;
    logic                 infl_q, infl_sel_q, infl_last_q;
    logic [1:0]           occ_q, wr_ptr_q, rd_ptr_q;
    logic [DATA_SIZE-1:0] buf_data_q [3];
    logic [2:0]           buf_sel_q, buf_last_q;
    logic                 push, pop;

    assign empty = {f1_empty, f0_empty};
    assign count = {f1_count, f0_count};
    assign cand0 = ~last_sel_q;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            full_ok[n] = count[n] >= BurstLen;
            // count != 0 guards against a zero-length burst if count drops as the timer expires
            tmo_ok[n]  = (FLUSH_TMO != 0) && (tmo_q[n] == FlushTmo) && !empty[n] &&
                         (count[n] != '0);
        end
    end

    always_comb begin
        pick_valid = 1'b1;
        pick_full  = 1'b1;
        pick       = cand0;
        if (full_ok[cand0]) begin
            pick = cand0;
        end else if (full_ok[last_sel_q]) begin
            pick = last_sel_q;
        end else begin
            pick_full = 1'b0;
            if (tmo_ok[cand0])           pick = cand0;
            else if (tmo_ok[last_sel_q]) pick = last_sel_q;
            else                         pick_valid = 1'b0;
        end
        pick_len = pick_full ? BurstLen : count[pick];
    end

    assign start = (state_q == StIdle) && pick_valid;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            tmo_d[n] = tmo_q[n];
            if ((count[n] == '0) || full_ok[n] || (start && (pick == 1'(n)))) begin
                tmo_d[n] = '0;
            end else if (!((state_q == StBurst) && (sel_q == 1'(n))) &&
                         (tmo_q[n] != FlushTmo)) begin
                tmo_d[n] = tmo_q[n] + TW'(1);
            end
        end
    end

    // Credit covers both buffered words and the read whose data lands next cycle.
    assign credit_ok  = ({1'b0, occ_q} + {2'b00, infl_q}) < 3'd3;
    assign issue      = (state_q == StBurst) && credit_ok && !empty[sel_q];
    assign last_issue = issue && (beat_q == len_q - CW'(1));

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StBurst;
            StBurst: if (last_issue) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        f0_rd_en = issue && !sel_q;
        f1_rd_en = issue && sel_q;
    end

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign push = infl_q;
    assign pop  = (occ_q != 2'd0) && out_ready;

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sel_q  <= 1'b1;
            sel_q       <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            infl_q      <= 1'b0;
            infl_sel_q  <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            buf_sel_q   <= '0;
            buf_last_q  <= '0;
            for (int i = 0; i < 3; i++) buf_data_q[i] <= '0;
        end else begin
            tmo_q       <= tmo_d;
            infl_q      <= issue;
            infl_sel_q  <= sel_q;
            infl_last_q <= last_issue;
            if (start) begin
                sel_q      <= pick;
                last_sel_q <= pick;
                len_q      <= pick_len;
                beat_q     <= '0;
            end else if (issue) begin
                beat_q <= beat_q + CW'(1);
            end
            if (push) begin
                buf_data_q[wr_ptr_q] <= infl_sel_q ? f1_dout : f0_dout;
                buf_sel_q[wr_ptr_q]  <= infl_sel_q;
                buf_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      occ_q <= occ_q + 2'd1;
            else if (!push && pop) occ_q <= occ_q - 2'd1;
        end
    end

    assign out_valid = occ_q != 2'd0;
    assign out_data  = buf_data_q[rd_ptr_q];
    assign out_sel   = buf_sel_q[rd_ptr_q];
    assign out_last  = buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_pp_rd_burst_sched.sv
// Scoreboard bench for pp_rd_burst_sched: FIFO models feed sequence-numbered data, a negedge
// monitor pops expected words and checks credit, rd_en exclusivity and stall stability.
module tb_pp_rd_burst_sched;
    localparam int unsigned DW  = 16;
    localparam int unsigned DS  = 10;
    localparam int unsigned BL  = 64;
    localparam int unsigned TMO = 256;

    logic          rd_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          f0_empty, f1_empty, f0_rd_en, f1_rd_en;
    logic [DS:0]   f0_count, f1_count;
    logic [DW-1:0] f0_dout, f1_dout, out_data;
    logic          out_valid, out_sel, out_last;
    logic          out_ready = 1'b1;

    always #5 rd_clk = ~rd_clk;

    pp_rd_burst_sched #(
        .DATA_SIZE (DW),
        .DEPTH_SIZE(DS),
        .BURST_LEN (BL),
        .FLUSH_TMO (TMO)
    ) dut (
        .rd_clk   (rd_clk),
        .rst_n    (rst_n),
        .f0_empty (f0_empty),
        .f0_count (f0_count),
        .f0_dout  (f0_dout),
        .f0_rd_en (f0_rd_en),
        .f1_empty (f1_empty),
        .f1_count (f1_count),
        .f1_dout  (f1_dout),
        .f1_rd_en (f1_rd_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_last (out_last)
    );

    // FIFO models: data word = {fifo id, read sequence number}
    int wr_cnt0 = 0, wr_cnt1 = 0, rd_cnt0, rd_cnt1;
    assign f0_count = 11'(wr_cnt0 - rd_cnt0);
    assign f1_count = 11'(wr_cnt1 - rd_cnt1);
    assign f0_empty = (wr_cnt0 == rd_cnt0);
    assign f1_empty = (wr_cnt1 == rd_cnt1);

    always @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt0 <= 0;
            rd_cnt1 <= 0;
            f0_dout <= '0;
            f1_dout <= '0;
        end else begin
            if (f0_rd_en) begin
                f0_dout <= {1'b0, 15'(rd_cnt0)};
                rd_cnt0 <= rd_cnt0 + 1;
            end
            if (f1_rd_en) begin
                f1_dout <= {1'b1, 15'(rd_cnt1)};
                rd_cnt1 <= rd_cnt1 + 1;
            end
        end
    end

    bit ready_mode = 1'b0;
    int rcnt = 0;
    always @(posedge rd_clk) begin
        #1;
        rcnt++;
        out_ready = ready_mode ? (rcnt % 3 == 0) : 1'b1;
    end

    int          n_checks = 0, n_fail = 0;
    int          exp_seq0 = 0, exp_seq1 = 0;
    logic [17:0] exp_q[$];
    int          pop_cyc[$];
    bit          forbid_f1 = 1'b0;

    task automatic push_burst(input bit n, input int len);
        for (int i = 0; i < len; i++) begin
            int seq = n ? exp_seq1 : exp_seq0;
            exp_q.push_back({n, (i == len - 1), n, 15'(seq)});
            if (n) exp_seq1++;
            else   exp_seq0++;
        end
    endtask

    // Monitor: sampled on the negedge, away from the active edge.
    int          cyc = 0, issued = 0, popped = 0;
    logic        stall_prev = 1'b0;
    logic [17:0] held;
    always @(negedge rd_clk) begin
        cyc++;
        if (!rst_n) begin
            issued = 0;
            popped = 0;
            stall_prev = 1'b0;
        end else begin
            n_checks++;
            if (f0_rd_en && f1_rd_en) begin
                n_fail++;
                $display("FAIL both_rd_en: f0_rd_en=%0b f1_rd_en=%0b required not both", f0_rd_en,
                         f1_rd_en);
            end
            n_checks++;
            if (issued - popped + int'(f0_rd_en | f1_rd_en) > 3) begin
                n_fail++;
                $display("FAIL credit: outstanding=%0d required <= 3",
                         issued - popped + int'(f0_rd_en | f1_rd_en));
            end
            if (forbid_f1) begin
                n_checks++;
                if (f1_rd_en) begin
                    n_fail++;
                    $display("FAIL no_f1_read: f1_rd_en=%0b required 0", f1_rd_en);
                end
            end
            if (stall_prev) begin
                n_checks++;
                if ({out_valid, out_sel, out_last, out_data} !== {1'b1, held}) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %0h required %0h",
                             {out_valid, out_sel, out_last, out_data}, {1'b1, held});
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h required no word",
                             {out_sel, out_last, out_data});
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    if ({out_sel, out_last, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard: got sel/last/data %0h required %0h",
                                 {out_sel, out_last, out_data}, e);
                    end
                end
                pop_cyc.push_back(cyc);
                popped++;
            end
            if (f0_rd_en || f1_rd_en) issued++;
            stall_prev = out_valid && !out_ready;
            held = {out_sel, out_last, out_data};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, exp_q.size(), 0);
        tick(4);
    endtask

    task automatic tmo_latency(input string name);
        int k = 0;
        do begin
            @(negedge rd_clk);
            k++;
        end while (!f1_rd_en && k < 400);
        check(name, k, 258);
    endtask

    initial begin
        int n, k;
        // Reset state and two back-to-back full bursts
        wr_cnt0 = 64;
        wr_cnt1 = 64;
        tick(3);
        check("reset_outputs", {out_valid, out_sel, out_last, f0_rd_en, f1_rd_en, out_data}, 0);
        push_burst(0, 64);
        push_burst(1, 64);
        pop_cyc.delete();
        @(negedge rd_clk);
        rst_n = 1'b1;
        wait_drain("t1_drain", 400);
        check("t1_pops", pop_cyc.size(), 128);
        if (pop_cyc.size() == 128) begin
            for (int i = 1; i < 128; i++)
                check("t1_gap", pop_cyc[i] - pop_cyc[i-1], (i == 64) ? 2 : 1);
        end

        // FIFO0 only, then FIFO1 fills while FIFO0 holds a short remainder
        forbid_f1 = 1'b1;
        wr_cnt0 += 200;
        push_burst(0, 64);
        push_burst(0, 64);
        push_burst(0, 64);
        wait_drain("t2_f0_bursts", 600);
        forbid_f1 = 1'b0;
        wr_cnt1 += 64;
        push_burst(1, 64);
        push_burst(0, 8);
        wait_drain("t2_alternate", 700);

        // Timeout-forced partial burst, twice to show the timer restarts
        wr_cnt1 += 5;
        push_burst(1, 5);
        tmo_latency("t3_tmo_latency");
        wait_drain("t3_drain", 50);
        wr_cnt1 += 5;
        push_burst(1, 5);
        tmo_latency("t3_tmo_latency_again");
        wait_drain("t3_drain_again", 50);

        // Back-pressure 1-in-3
        ready_mode = 1'b1;
        wr_cnt0 += 64;
        push_burst(0, 64);
        wait_drain("t4_drain", 400);
        ready_mode = 1'b0;
        tick(2);

        // Reset mid-burst
        wr_cnt0 += 64;
        push_burst(0, 64);
        n = 0;
        k = 0;
        while (n < 20 && k < 200) begin
            @(negedge rd_clk);
            k++;
            if (f0_rd_en) n++;
        end
        check("t5_reach_beat20", n, 20);
        #1 rst_n = 1'b0;
        #1 check("t5_reset_outputs",
                 {out_valid, out_sel, out_last, f0_rd_en, f1_rd_en, out_data}, 0);
        exp_q.delete();
        wr_cnt0 = 64;
        wr_cnt1 = 64;
        exp_seq0 = 0;
        exp_seq1 = 0;
        push_burst(0, 64);
        push_burst(1, 64);
        tick(3);
        @(negedge rd_clk);
        rst_n = 1'b1;
        wait_drain("t5_drain", 400);

        // Strict alternation over 8 bursts
        wr_cnt0 += 256;
        wr_cnt1 += 256;
        for (int b = 0; b < 4; b++) begin
            push_burst(0, 64);
            push_burst(1, 64);
        end
        wait_drain("t6_drain", 800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
